// File: rtl/vecmem_pkg.sv
// Shared definitions for the image vector memory path: lane geometry, vector type,
// fetch FSM states and image-size helper functions.
package vecmem_pkg;

   localparam int unsigned LANES         = 16;
   localparam int unsigned PIX_PER_CHUNK = 8;

   typedef logic [LANES-1:0][15:0] vec_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } fetch_state_e;

   function automatic int unsigned chunks_per_row(input int unsigned width);
      return width / PIX_PER_CHUNK;
   endfunction

   function automatic int unsigned total_chunks(input int unsigned width,
                                                input int unsigned height);
      return chunks_per_row(width) * height;
   endfunction

   // Keep only the lanes that carry pixels; the rest of the memory word is don't-care.
   function automatic vec_t mask_chunk(input vec_t v);
      vec_t m;
      m = '0;
      for (int unsigned i = 0; i < PIX_PER_CHUNK; i++) begin
         m[i] = v[i];
      end
      return m;
   endfunction

endpackage

// File: rtl/fetch_pos_counter.sv
// Row/column chunk position counter with advance enable; flags the final chunk of the image.
// Also used by the write-back sequencer.
module fetch_pos_counter #(
   parameter int unsigned COLS = 12,
   parameter int unsigned ROWS = 96
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       adv_i,
   output logic [7:0] row_o,
   output logic [7:0] col_o,
   output logic       last_o
);

   localparam logic [7:0] ColMax = 8'(COLS - 1);
   localparam logic [7:0] RowMax = 8'(ROWS - 1);

   logic [7:0] row_q, row_d;
   logic [7:0] col_q, col_d;

   assign row_o  = row_q;
   assign col_o  = col_q;
   assign last_o = (row_q == RowMax) && (col_q == ColMax);

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr_i) begin
         row_d = '0;
         col_d = '0;
      end else if (adv_i) begin
         if (col_q == ColMax) begin
            col_d = '0;
            row_d = (row_q == RowMax) ? 8'd0 : row_q + 8'd1;
         end else begin
            col_d = col_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/image_vector_fetcher.sv
// Walks an image in 8-pixel chunks, registers each memory vector and streams it out over
// valid/ready. Optional stall counter built when FETCH_PERF_CNT_EN is defined.
module image_vector_fetcher
   import vecmem_pkg::*;
#(
   parameter int unsigned IMAGE_WIDTH  = 96,
   parameter int unsigned IMAGE_HEIGHT = 96
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] base_addr_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] mem_addr_o,
   input  vec_t        mem_rd_i,
   output vec_t        vec_data_o,
   output logic        vec_valid_o,
   input  logic        vec_ready_i,
   output logic        vec_last_o,
   output logic [7:0]  vec_row_o,
   output logic [7:0]  vec_col_o,
   output logic [15:0] stall_cycles_o
);

   fetch_state_e state_q, state_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [15:0]  mem_addr_q, mem_addr_d;
   vec_t         vec_data_q, vec_data_d;
   logic         vec_valid_q, vec_valid_d;
   logic         vec_last_q, vec_last_d;
   logic [7:0]   vec_row_q, vec_row_d;
   logic [7:0]   vec_col_q, vec_col_d;

   logic       start_ok, load, accept, pos_clr;
   logic [7:0] pos_row, pos_col;
   logic       pos_last;

   // A start seen during the done cycle belongs to the scan that just finished.
   assign start_ok = (state_q == StIdle) && start_i && !done_q;
   assign load     = (state_q == StRun) && (!vec_valid_q || vec_ready_i);
   assign accept   = vec_valid_q && vec_ready_i;
   assign pos_clr  = start_ok;

   fetch_pos_counter #(
      .COLS (chunks_per_row(IMAGE_WIDTH)),
      .ROWS (IMAGE_HEIGHT)
   ) u_pos (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (pos_clr),
      .adv_i  (load),
      .row_o  (pos_row),
      .col_o  (pos_col),
      .last_o (pos_last)
   );

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      mem_addr_d  = mem_addr_q;
      vec_data_d  = vec_data_q;
      vec_valid_d = vec_valid_q;
      vec_last_d  = vec_last_q;
      vec_row_d   = vec_row_q;
      vec_col_d   = vec_col_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               mem_addr_d = base_addr_i;
               busy_d     = 1'b1;
               state_d    = StRun;
            end
         end
         StRun: begin
            if (load) begin
               vec_data_d  = mask_chunk(mem_rd_i);
               vec_valid_d = 1'b1;
               vec_row_d   = pos_row;
               vec_col_d   = pos_col;
               vec_last_d  = pos_last;
               mem_addr_d  = mem_addr_q + 16'(PIX_PER_CHUNK);
               if (pos_last) state_d = StDrain;
            end
         end
         StDrain: begin
            if (accept) begin
               vec_valid_d = 1'b0;
               vec_last_d  = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         vec_data_q  <= '0;
         vec_valid_q <= 1'b0;
         vec_last_q  <= 1'b0;
         vec_row_q   <= '0;
         vec_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_addr_q  <= mem_addr_d;
         vec_data_q  <= vec_data_d;
         vec_valid_q <= vec_valid_d;
         vec_last_q  <= vec_last_d;
         vec_row_q   <= vec_row_d;
         vec_col_q   <= vec_col_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_ok) begin
         stall_d = '0;
      end else if (vec_valid_q && !vec_ready_i && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign mem_addr_o  = mem_addr_q;
   assign vec_data_o  = vec_data_q;
   assign vec_valid_o = vec_valid_q;
   assign vec_last_o  = vec_last_q;
   assign vec_row_o   = vec_row_q;
   assign vec_col_o   = vec_col_q;

endmodule

// File: tb/tb_image_vector_fetcher.sv
// Self-checking bench for image_vector_fetcher: directed scans with a chunk scoreboard,
// a spot-check table, and sequences for reset, back-pressure, start filtering and wrap.
module tb_image_vector_fetcher;
   import vecmem_pkg::*;

   localparam int NCHUNK = 1152;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic        busy, done;
   logic [15:0] mem_addr;
   vec_t        mem_rd, vec_data;
   logic        vec_valid, vec_last;
   logic        vec_ready = 1'b0;
   logic [7:0]  vec_row, vec_col;
   logic [15:0] stall;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   image_vector_fetcher dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .base_addr_i    (base_addr),
      .busy_o         (busy),
      .done_o         (done),
      .mem_addr_o     (mem_addr),
      .mem_rd_i       (mem_rd),
      .vec_data_o     (vec_data),
      .vec_valid_o    (vec_valid),
      .vec_ready_i    (vec_ready),
      .vec_last_o     (vec_last),
      .vec_row_o      (vec_row),
      .vec_col_o      (vec_col),
      .stall_cycles_o (stall)
   );

   // Memory content: a bijective scramble of the word address.
   function automatic logic [15:0] pix(input logic [15:0] a);
      return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
   endfunction

   function automatic vec_t exp_chunk(input logic [15:0] b, input int k);
      vec_t v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i] = pix(b + 16'(8 * k + i));
      return v;
   endfunction

   always_comb begin
      mem_rd = '0;
      for (int l = 0; l < 16; l++) mem_rd[l] = pix(mem_addr + 16'(l));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard / monitor state
   int          n_acc, seq_err, stab_err, last_cnt, busy_falls, done_cnt, stall_seen;
   int          first_cyc, last_cyc;
   logic [15:0] exp_base;
   logic [7:0]  row_a [NCHUNK];
   logic [7:0]  col_a [NCHUNK];
   logic        last_a[NCHUNK];
   logic [15:0] lane0_a[2];
   logic        p_stall = 1'b0;
   logic        p_busy = 1'b0;
   vec_t        p_data;
   logic [7:0]  p_row, p_col;

   always @(negedge clk) begin
      if (p_stall && (vec_data !== p_data || vec_row !== p_row || vec_col !== p_col ||
                      vec_valid !== 1'b1)) stab_err++;
      p_stall = vec_valid && !vec_ready && !rst;
      if (p_stall) stall_seen++;
      p_data = vec_data;
      p_row  = vec_row;
      p_col  = vec_col;
      if (p_busy && !busy) busy_falls++;
      p_busy = busy;
      if (done) done_cnt++;
      if (!rst && vec_valid && vec_ready) begin
         if (n_acc < NCHUNK) begin
            if (vec_data !== exp_chunk(exp_base, n_acc) || vec_row !== 8'(n_acc / 12) ||
                vec_col !== 8'(n_acc % 12) || vec_last !== (n_acc == NCHUNK - 1)) seq_err++;
            row_a[n_acc]  = vec_row;
            col_a[n_acc]  = vec_col;
            last_a[n_acc] = vec_last;
            if (n_acc < 2) lane0_a[n_acc] = vec_data[0];
            if (n_acc == 0) first_cyc = cyc;
            last_cyc = cyc;
         end else begin
            seq_err++;
         end
         if (vec_last) last_cnt++;
         n_acc++;
      end
   end

   task automatic reset_mon(input logic [15:0] b);
      n_acc = 0; seq_err = 0; stab_err = 0; last_cnt = 0; busy_falls = 0; done_cnt = 0;
      stall_seen = 0; first_cyc = -1; last_cyc = -1; exp_base = b;
      lane0_a[0] = 'x; lane0_a[1] = 'x;
   endtask

   // mode 0: ready always high; 1: random 50%; 2: ready low for 5 cycles on chunk 3
   task automatic run_scan(input logic [15:0] b, input int mode, input bit poke,
                           output int t_start, output int done_cyc, output bit got_done,
                           output logic [15:0] stall_at_done, output logic [15:0] addr0);
      int hold = 0;
      int g = 0;
      bit poked = 1'b0;
      reset_mon(b);
      base_addr = b;
      start = 1'b1;
      vec_ready = 1'b1;
      t_start = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      addr0 = mem_addr;
      got_done = 1'b0;
      done_cyc = 0;
      stall_at_done = 'x;
      while (!got_done && g < 6000) begin
         case (mode)
            1: vec_ready = 1'($urandom_range(0, 1));
            2: if (vec_valid && n_acc == 3 && hold < 5) begin
                  vec_ready = 1'b0;
                  hold++;
               end else begin
                  vec_ready = 1'b1;
               end
            default: vec_ready = 1'b1;
         endcase
         start = poke && !poked && (n_acc == 500);
         if (start) poked = 1'b1;
         @(posedge clk); #1;
         g++;
         if (done) begin
            got_done = 1'b1;
            done_cyc = cyc;
            stall_at_done = stall;
         end
      end
      start = 1'b0;
      if (poke) begin
         start = 1'b1;  // lands in the done cycle
         @(posedge clk); #1;
         start = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int idx;
      int row;
      int col;
      int last;
   } spot_t;

   spot_t spots[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int          ts, dc, g;
      bit          gd;
      logic [15:0] sd, a0;
      logic [15:0] exp_stall;

      spots[0] = '{0, 0, 0, 0};
      spots[1] = '{11, 0, 11, 0};
      spots[2] = '{12, 1, 0, 0};
      spots[3] = '{13, 1, 1, 0};
      spots[4] = '{1150, 95, 10, 0};
      spots[5] = '{1151, 95, 11, 1};

      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(vec_valid), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_data_zero", 32'(vec_data == '0), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Scan interrupted by reset after 100 chunks
      reset_mon(16'h0000);
      base_addr = 16'h0000;
      start = 1'b1;
      vec_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      g = 0;
      while (n_acc < 100 && g < 500) begin
         @(posedge clk); #1;
         g++;
      end
      chk("midrst_reached100", 32'(n_acc >= 100), 32'd1);
      chk("midrst_seq_before", 32'(seq_err), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_valid", 32'(vec_valid), 32'd0);
      chk("midrst_last", 32'(vec_last), 32'd0);
      chk("midrst_rowcol", 32'({vec_row, vec_col}), 32'd0);
      chk("midrst_addr", 32'(mem_addr), 32'd0);
      chk("midrst_data_zero", 32'(vec_data == '0), 32'd1);
      chk("midrst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      vec_ready = 1'b0;

      // Full scan, ready=1, base 0, with start pulses while busy and in the done cycle
      run_scan(16'h0000, 0, 1'b1, ts, dc, gd, sd, a0);
      chk("full_done_seen", 32'(gd), 32'd1);
      chk("full_addr_at_start", 32'(a0), 32'h0000);
      chk("full_count", 32'(n_acc), 32'(NCHUNK));
      chk("full_seq_err", 32'(seq_err), 32'd0);
      chk("full_replay_chunk0", 32'(lane0_a[0]), 32'(pix(16'h0000)));
      chk("full_first_latency", 32'(first_cyc - ts), 32'd1);
      chk("full_consecutive", 32'(last_cyc - first_cyc), 32'(NCHUNK - 1));
      chk("full_done_latency", 32'(dc - ts), 32'd1153);
      chk("full_last_once", 32'(last_cnt), 32'd1);
      chk("full_done_pulses", 32'(done_cnt), 32'd1);
      chk("full_busy_falls", 32'(busy_falls), 32'd1);
      chk("full_idle_busy", 32'(busy), 32'd0);
      chk("full_idle_valid", 32'(vec_valid), 32'd0);
      chk("full_addr_hold", 32'(mem_addr), 32'h2400);
      chk("full_stall", 32'(sd), 32'd0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("spot%0d_row", spots[i].idx), 32'(row_a[spots[i].idx]), 32'(spots[i].row));
         chk($sformatf("spot%0d_col", spots[i].idx), 32'(col_a[spots[i].idx]), 32'(spots[i].col));
         chk($sformatf("spot%0d_last", spots[i].idx), 32'(last_a[spots[i].idx]),
             32'(spots[i].last));
      end

      // Back-pressure: 5 cycles of ready low on chunk 3
`ifdef FETCH_PERF_CNT_EN
      exp_stall = 16'd5;
`else
      exp_stall = 16'd0;
`endif
      run_scan(16'h0000, 2, 1'b0, ts, dc, gd, sd, a0);
      chk("bp_done_seen", 32'(gd), 32'd1);
      chk("bp_count", 32'(n_acc), 32'(NCHUNK));
      chk("bp_seq_err", 32'(seq_err), 32'd0);
      chk("bp_stall_observed", 32'(stall_seen), 32'd5);
      chk("bp_stable", 32'(stab_err), 32'd0);
      chk("bp_stall_cnt", 32'(sd), 32'(exp_stall));
      chk("bp_done_latency", 32'(dc - ts), 32'd1158);

      // Random back-pressure from base 0x0100
      run_scan(16'h0100, 1, 1'b0, ts, dc, gd, sd, a0);
      chk("rnd_done_seen", 32'(gd), 32'd1);
      chk("rnd_count", 32'(n_acc), 32'(NCHUNK));
      chk("rnd_seq_err", 32'(seq_err), 32'd0);
      chk("rnd_stable", 32'(stab_err), 32'd0);
      chk("rnd_chunk0", 32'(lane0_a[0]), 32'(pix(16'h0100)));

      // 16-bit address wrap from base 0xFFFC
      run_scan(16'hFFFC, 0, 1'b0, ts, dc, gd, sd, a0);
      chk("wrap_done_seen", 32'(gd), 32'd1);
      chk("wrap_addr_at_start", 32'(a0), 32'hFFFC);
      chk("wrap_chunk0", 32'(lane0_a[0]), 32'(pix(16'hFFFC)));
      chk("wrap_chunk1", 32'(lane0_a[1]), 32'(pix(16'h0004)));
      chk("wrap_seq_err", 32'(seq_err), 32'd0);
      chk("wrap_addr_hold", 32'(mem_addr), 32'h23FC);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
